// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional frame encoder and decoder:
// FSM state type, default code parameters and a counter-width helper.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2
    } state_t;

    localparam int unsigned K_DEF       = 3;
    localparam logic [2:0]  G0_DEF      = 3'b111;
    localparam logic [2:0]  G1_DEF      = 3'b101;
    localparam int unsigned MAX_LEN_DEF = 256;

    // Bits needed to hold values 0..n inclusive.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/conv_core.sv
// Shift register and generator XORs of a rate-1/2 convolutional encoder.
// The code word is combinational in the current bit u and the stored history;
// 'clear' makes the history read as zero so a new frame starts from the
// all-zero state in the same cycle its first bit is coded.
module conv_core
    import conv_pkg::*;
#(
    parameter int unsigned    K  = K_DEF,
    parameter logic [K-1:0]   G0 = G0_DEF,
    parameter logic [K-1:0]   G1 = G1_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift,
    input  logic       clear,
    input  logic       u,
    output logic [1:0] code
);

    // sr[K-2] is r1 (most recent previous bit), sr[0] is r(K-1)
    logic [K-2:0] sr;
    logic [K-2:0] hist;
    logic [K-1:0] vec;

    // Form {u, r1..r(K-1)} and the two generator parities
    always_comb begin
        hist = clear ? '0 : sr;
        vec  = {u, hist};
        code = {^(G0 & vec), ^(G1 & vec)};
    end

    // Shift the current bit into the history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (shift) begin
            sr <= vec[K-1:1];
        end
    end

endmodule

// File: rtl/conv_frame_encoder.sv
// Framed convolutional encoder: codes each accepted data bit into a 2-bit
// symbol, appends K-1 zero tail symbols per frame, marks sop/eop, counts
// completed frames and forces termination after MAX_LEN bits.
module conv_frame_encoder
    import conv_pkg::*;
#(
    parameter int unsigned  K       = K_DEF,
    parameter logic [K-1:0] G0      = G0_DEF,
    parameter logic [K-1:0] G1      = G1_DEF,
    parameter int unsigned  MAX_LEN = MAX_LEN_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        d_in,
    input  logic        last_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [1:0]  d_out,
    output logic        sop_o,
    output logic        eop_o,
    input  logic        ready_i,
    output logic [15:0] frames_o,
    output logic        ovf_o
);

    localparam int unsigned BW = cnt_width(MAX_LEN);
    localparam int unsigned TW = cnt_width(K);

    state_t          state;
    logic [BW-1:0]   bit_cnt;
    logic [TW-1:0]   tail_cnt;

    logic            load;
    logic            accept;
    logic            tail_emit;
    logic            tail_final;
    logic            shift;
    logic            clear;
    logic            u;
    logic            force_last;
    logic            is_last;
    logic            eop_take;
    logic [1:0]      code;

    // Handshake and datapath control decoded from state and output register
    always_comb begin
        load       = !valid_o || ready_i;
        ready_o    = (state != TAIL) && load;
        accept     = valid_i && ready_o;
        tail_emit  = (state == TAIL) && load && (tail_cnt != TW'(K - 1));
        tail_final = (tail_cnt == TW'(K - 2));
        shift      = accept || tail_emit;
        clear      = accept && (state == IDLE);
        u          = accept && d_in;
        force_last = (bit_cnt == BW'(MAX_LEN - 1));
        is_last    = last_i || force_last;
        eop_take   = valid_o && ready_i && eop_o;
    end

    conv_core #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .shift (shift),
        .clear (clear),
        .u     (u),
        .code  (code)
    );

    // Output symbol register: reloads only when empty or being consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_o <= 1'b0;
            d_out   <= '0;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
        end else if (load) begin
            valid_o <= shift;
            if (shift) begin
                d_out <= code;
            end
            sop_o   <= clear;
            eop_o   <= tail_emit && tail_final;
        end
    end

    // Frame FSM with bit/tail counters and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            tail_cnt <= '0;
            ovf_o    <= 1'b0;
        end else begin
            case (state)
                IDLE, DATA: begin
                    if (accept) begin
                        if (is_last) begin
                            state    <= TAIL;
                            bit_cnt  <= '0;
                            tail_cnt <= '0;
                            if (!last_i) begin
                                ovf_o <= 1'b1;
                            end
                        end else begin
                            state   <= DATA;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                TAIL: begin
                    if (tail_emit) begin
                        tail_cnt <= tail_cnt + 1'b1;
                    end
                    if (eop_take) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completed-frame counter, advanced when the eop symbol is consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_o <= '0;
        end else if (eop_take) begin
            frames_o <= frames_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Randomized self-checking bench for conv_frame_encoder. Expected symbols are
// computed from the convolution definition over each whole frame (data bits
// followed by K-1 zeros) and consumed in order by a handshake monitor.
module tb_conv_frame_encoder;
    import conv_pkg::*;

    localparam int unsigned    TK  = K_DEF;
    localparam logic [TK-1:0]  TG0 = G0_DEF;
    localparam logic [TK-1:0]  TG1 = G1_DEF;
    localparam int unsigned    TML = MAX_LEN_DEF;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        d_in;
    logic        last_i;
    logic        ready_o;
    logic        valid_o;
    logic [1:0]  d_out;
    logic        sop_o;
    logic        eop_o;
    logic        ready_i;
    logic [15:0] frames_o;
    logic        ovf_o;

    conv_frame_encoder #(
        .K       (TK),
        .G0      (TG0),
        .G1      (TG1),
        .MAX_LEN (TML)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .d_in     (d_in),
        .last_i   (last_i),
        .ready_o  (ready_o),
        .valid_o  (valid_o),
        .d_out    (d_out),
        .sop_o    (sop_o),
        .eop_o    (eop_o),
        .ready_i  (ready_i),
        .frames_o (frames_o),
        .ovf_o    (ovf_o)
    );

    typedef struct {
        logic [1:0] sym;
        logic       sop;
        logic       eop;
    } exp_sym_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        fb[$];
    exp_sym_t    expq[$];
    logic [15:0] frames_exp = '0;
    logic        ovf_exp = 1'b0;
    int unsigned stall_left = 0;
    bit          rand_ready = 1'b0;
    bit          gaps = 1'b0;
    bit          hold_pending = 1'b0;
    logic [3:0]  held;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: forced stalls take priority, otherwise random or always-ready
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0) begin
                ready_i = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                ready_i = ($urandom_range(0, 3) != 0);
            end else begin
                ready_i = 1'b1;
            end
        end
    end

    // Reference: symbol i is coded from bits i, i-1, .. i-K+1 of the zero-padded frame
    task automatic model_frame();
        int           n;
        int           idx;
        logic [TK-1:0] w;
        exp_sym_t     e;
        n = fb.size();
        for (int i = 0; i < n + int'(TK) - 1; i++) begin
            for (int j = 0; j < int'(TK); j++) begin
                idx = i - j;
                w[int'(TK) - 1 - j] = (idx >= 0 && idx < n) ? fb[idx] : 1'b0;
            end
            e.sym = {^(TG0 & w), ^(TG1 & w)};
            e.sop = (i == 0);
            e.eop = (i == n + int'(TK) - 2);
            expq.push_back(e);
        end
    endtask

    task automatic make_frame(input int unsigned n);
        fb.delete();
        repeat (n) fb.push_back(1'($urandom));
    endtask

    // Present one bit and return at posedge+1 of the cycle it was accepted
    task automatic send_bit(input logic b, input logic l);
        int unsigned t;
        if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                valid_i = 1'b0;
                d_in    = 1'($urandom);
                last_i  = 1'($urandom);
                @(posedge clk);
                #1;
            end
        end
        valid_i = 1'b1;
        d_in    = b;
        last_i  = l;
        t = 0;
        forever begin
            @(negedge clk);
            if (ready_o) break;
            t++;
            if (t > 1000) begin
                check("accept_timeout", 32'(0), 32'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        last_i  = 1'b0;
        d_in    = 1'b0;
    endtask

    // Send the bits in fb as one frame, then follow its tail to completion
    task automatic send_frame(input bit use_last);
        int unsigned t;
        int          n;
        n = fb.size();
        model_frame();
        for (int i = 0; i < n; i++) begin
            send_bit(fb[i], use_last && (i == n - 1));
        end
        if (!use_last && n == int'(TML)) ovf_exp = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            check("tail_ready_o", 32'(ready_o), 32'(0));
            if (valid_o && ready_i && eop_o) break;
            t++;
            if (t > 1000) begin
                check("eop_timeout", 32'(0), 32'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        frames_exp = frames_exp + 16'd1;
        check("frames_o", 32'(frames_o), 32'(frames_exp));
        check("ovf_o", 32'(ovf_o), 32'(ovf_exp));
    endtask

    // Handshake monitor: in-order symbol check plus stall stability
    always @(negedge clk) begin
        exp_sym_t e;
        if (!rst) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 32'(valid_o), 32'(1));
                check("hold_fields", 32'({d_out, sop_o, eop_o}), 32'(held));
            end
            hold_pending = valid_o && !ready_i;
            held = {d_out, sop_o, eop_o};
            if (valid_o && !ready_i) check("stall_ready_o", 32'(ready_o), 32'(0));
            if (valid_o && ready_i) begin
                if (expq.size() == 0) begin
                    check("extra_symbol", 32'(1), 32'(0));
                end else begin
                    e = expq.pop_front();
                    check("d_out", 32'(d_out), 32'(e.sym));
                    check("sop_o", 32'(sop_o), 32'(e.sop));
                    check("eop_o", 32'(eop_o), 32'(e.eop));
                end
            end
        end
    end

    task automatic check_cleared(input string tag);
        check({tag, "_valid_o"},  32'(valid_o),  32'(0));
        check({tag, "_d_out"},    32'(d_out),    32'(0));
        check({tag, "_sop_o"},    32'(sop_o),    32'(0));
        check({tag, "_eop_o"},    32'(eop_o),    32'(0));
        check({tag, "_ovf_o"},    32'(ovf_o),    32'(0));
        check({tag, "_frames_o"}, 32'(frames_o), 32'(0));
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        valid_i = 1'b0;
        last_i = 1'b0;
        expq.delete();
        frames_exp = '0;
        ovf_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(ready_o), 32'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b0;
        valid_i = 1'b0;
        d_in    = 1'b0;
        last_i  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(ready_o), 32'(1));
        @(posedge clk);
        #1;

        // Reference frame 1,0,1,1 with downstream always ready
        fb = {1'b1, 1'b0, 1'b1, 1'b1};
        send_frame(1'b1);

        // Single-bit frame
        fb = {1'b1};
        send_frame(1'b1);

        // Same reference frame with a 3-cycle downstream stall mid-frame
        fb = {1'b1, 1'b0, 1'b1, 1'b1};
        fork
            send_frame(1'b1);
            begin
                @(posedge clk);
                @(negedge clk);
                stall_left = 3;
            end
        join

        // Random frames with input gaps and random backpressure
        gaps = 1'b1;
        rand_ready = 1'b1;
        repeat (40) begin
            make_frame($urandom_range(1, 20));
            send_frame(1'b1);
        end

        // MAX_LEN bits without last_i: forced termination and sticky overflow
        check("ovf_before", 32'(ovf_o), 32'(0));
        make_frame(TML);
        send_frame(1'b0);
        make_frame($urandom_range(1, 8));
        send_frame(1'b1);

        // Asynchronous reset while bit 3 of a 10-bit frame is presented
        gaps = 1'b0;
        rand_ready = 1'b0;
        make_frame(10);
        model_frame();
        send_bit(fb[0], 1'b0);
        send_bit(fb[1], 1'b0);
        valid_i = 1'b1;
        d_in = fb[2];
        #2;
        rst = 1'b0;
        #1;
        check_cleared("async_reset");
        expq.delete();
        frames_exp = '0;
        ovf_exp = 1'b0;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(ready_o), 32'(1));
        @(posedge clk);
        #1;
        fb = {1'b1, 1'b0, 1'b1, 1'b1};
        send_frame(1'b1);

        // 65536 back-to-back one-bit frames wrap the frame counter
        reset_pulse();
        repeat (65536) begin
            make_frame(1);
            send_frame(1'b1);
        end
        check("frames_wrap", 32'(frames_o), 32'(0));

        repeat (4) @(posedge clk);
        check("queue_drained", 32'(expq.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_frame_encoder.md
CONV_FRAME_ENCODER -- requirements
Module: conv_frame_encoder

Interface
REQ-001 SHALL have parameters: K, default 3, constraint length; G0, default 3'b111, generator for d_out[1]; G1, default 3'b101, generator for d_out[0]; MAX_LEN, default 256, maximum data bits per frame.
REQ-002 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  input bit valid.
- d_in  in  1  input data bit.
- last_i  in  1  marks the final data bit of a frame.
- ready_o  out  1  input accepted when valid_i && ready_o.
- valid_o  out  1  output symbol valid.
- d_out  out  2  coded symbol {c0,c1}.
- sop_o  out  1  first symbol of a frame.
- eop_o  out  1  last tail symbol of a frame.
- ready_i  in  1  downstream accepts the symbol when valid_o && ready_i.
- frames_o  out  16  count of completed frames.
- ovf_o  out  1  sticky MAX_LEN overflow flag.

Function
REQ-003 SHALL compute c0 = XOR(G0 & {u,r1..r(K-1)}) and c1 = XOR(G1 & {u,r1..r(K-1)}), where u is the current input and r1 is the most recent previous input.
REQ-004 SHALL implement a three-state FSM (IDLE, DATA, TAIL) with these transitions:
- IDLE->DATA on accepting a bit without last_i.
- IDLE->TAIL or DATA->TAIL on accepting a bit with last_i.
- TAIL->IDLE when the (K-1)th tail symbol is accepted downstream.
REQ-005 SHALL drive ready_o = (state != TAIL) && (!valid_o || ready_i), so that no input is accepted during TAIL.
REQ-006 SHALL register the output: a symbol appears on valid_o/d_out exactly one cycle after its input bit is accepted.
REQ-007 SHALL hold valid_o, d_out, sop_o and eop_o stable while valid_o && !ready_i; no symbol may be dropped or duplicated.
REQ-008 SHALL feed K-1 zero bits in TAIL, one per cycle in which the output register is free, so the shift register returns to all-zero at frame end.
REQ-009 SHALL assert sop_o only with the first data symbol of a frame, and eop_o only with the last tail symbol.
REQ-010 SHALL force termination when the accepted bit count reaches MAX_LEN without last_i:
- treat that bit as last;
- set ovf_o, which remains set until reset.
REQ-011 SHALL increment frames_o, wrapping modulo 2^16, in the cycle the eop_o symbol is accepted downstream.
REQ-012 SHALL ignore last_i when valid_i is low; a frame of one bit (valid_i && last_i in IDLE) SHALL produce 1+(K-1) symbols with sop_o and eop_o on different symbols.
REQ-013 SHALL clear the shift register to zero on entry to DATA/TAIL from IDLE.

Reset
REQ-014 SHALL, on rst low (asynchronous), set:
- state to IDLE;
- the shift register, bit counter, tail counter and frames_o to 0;
- valid_o, sop_o, eop_o, ovf_o and d_out to 0.
REQ-015 SHALL, on reset mid-frame, discard the partial frame; the first accepted bit after reset release begins a new frame with sop_o.
REQ-016 SHALL drive ready_o high in the first cycle after reset release.

Structure
REQ-017 SHALL place the state enum type, K, G0, G1 and MAX_LEN defaults in a shared package, conv_pkg, also used by the decoder.
REQ-018 SHALL instantiate one sub-module, conv_core, which holds the shift register and generator XORs (shift, clear, u in; {c0,c1} out).

Verification
REQ-019 SHALL verify that input bits 1,0,1,1 (last on 4th) with ready_i=1 produce d_out = 11,10,00,01,01,11, sop_o on the 1st symbol, eop_o on the 6th, and frames_o=1.
REQ-020 SHALL verify that holding ready_i=0 for 3 cycles mid-frame keeps ready_o=0 and d_out stable, and that the symbol sequence is unchanged versus REQ-019.
REQ-021 SHALL verify that a single bit 1 with last_i produces symbols 11,10,11 with sop_o on the 1st and eop_o on the 3rd.
REQ-022 SHALL verify that 256 bits without last_i produce ovf_o=1, exactly 2 tail symbols after bit 256, eop_o on the last, and ready_o=0 during those tail cycles.
REQ-023 SHALL verify that asserting rst low during DATA (bit 3 of 10) makes all outputs 0 asynchronously, and that the next frame 1,0,1,1 again yields REQ-019 symbols.
REQ-024 SHALL verify that 65536 back-to-back one-bit frames wrap frames_o to 0.
